// File: rtl/nco_pkg.sv
// nco_pkg: phase constants and saturation bounds for the 1.2.13 radian phase format
package nco_pkg;
  localparam int PHASE_W = 16;
  localparam int PI_POS = 25736;
  localparam int PI_NEG = -25736;
  localparam int TWO_PI = 51472;
  localparam int SAT_MAX = PI_POS - 1;
  localparam int SAT_MIN = PI_NEG;
endpackage

// File: rtl/phase_wrap.sv
// phase_wrap: modular adder folding a+b back into [-pi, pi) with the remainder kept
module phase_wrap import nco_pkg::*; #(
  parameter int PW = PHASE_W
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] y
);
  localparam logic signed [PW:0] P_POS = (PW+1)'(PI_POS);
  localparam logic signed [PW:0] P_NEG = (PW+1)'(PI_NEG);
  localparam logic signed [PW:0] P_TWO = (PW+1)'(TWO_PI);
  logic signed [PW:0] s, r;
  always_comb begin
    s = $signed({a[PW-1], a}) + $signed({b[PW-1], b});
    r = (s >= P_POS) ? s - P_TWO : (s < P_NEG) ? s + P_TWO : s;
    y = r[PW-1:0];
  end
endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: round-robin multi-channel phase accumulator with AXI-Stream style output
// Optional per-channel phase offset enabled by defining NCO_PHASE_OFFSET_EN.
module nco_phase_gen import nco_pkg::*; #(
  parameter int NCH = 4,
  parameter int PW = PHASE_W,
  parameter int DEFAULT_INC = 256,
  parameter int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [PW-1:0] cfg_inc,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [PW-1:0] cfg_off,
`endif
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [PW-1:0] m_tdata,
  output logic [CW-1:0] m_tuser
);
  localparam logic [PW-1:0] SAT_HI = PW'(SAT_MAX);
  localparam logic [PW-1:0] SAT_LO = PW'(SAT_MIN);
  localparam logic [PW-1:0] INC_RST = PW'(DEFAULT_INC > SAT_MAX ? SAT_MAX : DEFAULT_INC < SAT_MIN ? SAT_MIN : DEFAULT_INC);
  function automatic logic [PW-1:0] sat(input logic [PW-1:0] v);
    return ($signed(v) > $signed(SAT_HI)) ? SAT_HI : ($signed(v) < $signed(SAT_LO)) ? SAT_LO : v;
  endfunction
  logic [PW-1:0] acc [NCH];
  logic [PW-1:0] inc [NCH];
  logic [CW-1:0] ptr;
  logic [PW-1:0] acc_nxt, word;
  logic issue, ch_ok;
  assign issue = en && (!m_tvalid || m_tready);
  assign ch_ok = {1'b0, cfg_ch} < (CW+1)'(NCH);
  phase_wrap #(.PW(PW)) u_acc (.a(acc[ptr]), .b(inc[ptr]), .y(acc_nxt));
`ifdef NCO_PHASE_OFFSET_EN
  logic [PW-1:0] off [NCH];
  phase_wrap #(.PW(PW)) u_off (.a(acc[ptr]), .b(off[ptr]), .y(word));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) off[i] <= '0;
    end else if (cfg_we && ch_ok) begin
      off[cfg_ch] <= sat(cfg_off);
    end
  end
`else
  assign word = acc[ptr];
`endif
  // inc is read for the issue before a same-cycle write lands, so the new step applies next time
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_RST;
      end
      ptr <= '0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tuser <= '0;
    end else begin
      if (issue) begin
        acc[ptr] <= acc_nxt;
        m_tdata <= word;
        m_tuser <= ptr;
        m_tvalid <= 1'b1;
        ptr <= (ptr == CW'(NCH-1)) ? '0 : ptr + 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (cfg_we && ch_ok) inc[cfg_ch] <= sat(cfg_inc);
    end
  end
endmodule
